// File: rtl/axi_pkg.sv
// ============================================================
// Package : axi_pkg
// Desc    : Shared AXI3 read/write channel types and address math
// Rev     : 1.0
// ============================================================
`default_nettype none

package axi_pkg;

  localparam int AXI_DATA_W = 64;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 4;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  // Address of the beat following addr; WRAP assumes a legal power-of-2 length.
  function automatic logic [AXI_ADDR_W-1:0] axi_next_addr(
    input logic [AXI_ADDR_W-1:0] addr,
    input logic [2:0]            size,
    input logic [AXI_LEN_W-1:0]  len,
    input burst_e                burst
  );
    logic [AXI_ADDR_W-1:0] bytes;
    logic [AXI_ADDR_W-1:0] blen;
    logic [AXI_ADDR_W-1:0] lo;
    bytes = 32'd1 << size;
    blen  = ({28'd0, len} + 32'd1) * bytes;
    lo    = addr & ~(blen - 32'd1);
    case (burst)
      FIXED:   axi_next_addr = addr;
      INCR:    axi_next_addr = (addr & ~(bytes - 32'd1)) + bytes;
      WRAP:    axi_next_addr = lo | ((addr + bytes) & (blen - 32'd1));
      default: axi_next_addr = addr;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
// ============================================================
// Module : axi_burst_addr_gen
// Desc   : Combinational next-beat address, burst legality and decode check
// Rev    : 1.0
// ============================================================
`default_nettype none

module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int                    MEM_DEPTH = 1024,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [AXI_ADDR_W-1:0]        i_addr,
  input  logic [2:0]                   i_size,
  input  logic [AXI_LEN_W-1:0]         i_len,
  input  burst_e                       i_burst,
  output logic [AXI_ADDR_W-1:0]        o_next_addr,
  output logic                         o_burst_err,
  output logic                         o_addr_err,
  output logic [$clog2(MEM_DEPTH)-1:0] o_word_idx
);

  localparam int         c_word_aw = $clog2(MEM_DEPTH);
  localparam logic [32:0] c_span   = 33'(MEM_DEPTH) << 3;

  logic [AXI_ADDR_W-1:0] w_bytes;
  logic [AXI_ADDR_W-1:0] w_offset;
  logic                  w_wrap_len_ok;
  logic                  w_wrap_bad;

  assign w_bytes  = 32'd1 << i_size;
  assign w_offset = i_addr - BASE_ADDR;

  always_comb begin
    w_wrap_len_ok = 1'b0;
    case (i_len)
      4'd1, 4'd3, 4'd7, 4'd15: w_wrap_len_ok = 1'b1;
      default:                 w_wrap_len_ok = 1'b0;
    endcase
  end

  assign w_wrap_bad  = (i_burst == WRAP) &&
                       (!w_wrap_len_ok || ((i_addr & (w_bytes - 32'd1)) != 32'd0));
  assign o_burst_err = (i_size > 3'd3) || (i_burst == RSVD) || w_wrap_bad;

  // Base is aligned to the window size, so one unsigned compare covers both ends.
  assign o_addr_err  = {1'b0, w_offset} >= c_span;
  assign o_word_idx  = w_offset[3 +: c_word_aw];
  assign o_next_addr = axi_next_addr(i_addr, i_size, i_len, i_burst);

endmodule

`default_nettype wire

// File: rtl/axi_rd_slave_mem.sv
// ============================================================
// Module : axi_rd_slave_mem
// Desc   : AXI3 read-channel slave backed by a preloadable 64-bit memory
// Rev    : 1.0
// ============================================================
`default_nettype none

module axi_rd_slave_mem
  import axi_pkg::*;
#(
  parameter int                    MEM_DEPTH = 1024,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AXI_ID_W-1:0]          ARID,
  input  logic [AXI_ADDR_W-1:0]        ARADDR,
  input  logic [AXI_LEN_W-1:0]         ARLEN,
  input  logic [2:0]                   ARSIZE,
  input  logic [1:0]                   ARBURST,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [AXI_ID_W-1:0]          RID,
  output logic [AXI_DATA_W-1:0]        RDATA,
  output logic [1:0]                   RRESP,
  output logic                         RLAST,
  output logic                         RVAILD,
  input  logic                         RREADY,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [AXI_DATA_W-1:0]        mem_wdata
);

  localparam int c_word_aw = $clog2(MEM_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  logic [AXI_DATA_W-1:0] mem [MEM_DEPTH];

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [AXI_ID_W-1:0]   r_rid;
  logic [AXI_DATA_W-1:0] r_rdata;
  resp_e                 r_rresp;
  logic [AXI_LEN_W-1:0]  r_beat_cnt;
  logic [AXI_ADDR_W-1:0] r_addr;
  logic [AXI_LEN_W-1:0]  r_len;
  logic [2:0]            r_size;
  burst_e                r_burst;
  logic                  r_slverr;

  logic                  w_arready_nxt;
  logic                  w_rvalid_nxt;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_load;

  logic [AXI_ADDR_W-1:0] w_g_addr;
  logic [2:0]            w_g_size;
  logic [AXI_LEN_W-1:0]  w_g_len;
  burst_e                w_g_burst;
  logic [AXI_ADDR_W-1:0] w_next_addr;
  logic                  w_burst_err;
  logic                  w_addr_err;
  logic [c_word_aw-1:0]  w_word_idx;
  logic                  w_slverr_now;
  resp_e                 w_resp_now;

  // In IDLE the generator looks at the AR channel so beat 0 is fetched at acceptance.
  assign w_g_addr  = (r_state == IDLE) ? ARADDR            : r_addr;
  assign w_g_size  = (r_state == IDLE) ? ARSIZE            : r_size;
  assign w_g_len   = (r_state == IDLE) ? ARLEN             : r_len;
  assign w_g_burst = (r_state == IDLE) ? burst_e'(ARBURST) : r_burst;

  axi_burst_addr_gen #(
    .MEM_DEPTH (MEM_DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .i_addr      (w_g_addr),
    .i_size      (w_g_size),
    .i_len       (w_g_len),
    .i_burst     (w_g_burst),
    .o_next_addr (w_next_addr),
    .o_burst_err (w_burst_err),
    .o_addr_err  (w_addr_err),
    .o_word_idx  (w_word_idx)
  );

  assign w_slverr_now = (r_state == IDLE) ? w_burst_err : r_slverr;

  always_comb begin
    w_resp_now = OKAY;
    if (w_slverr_now) begin
      w_resp_now = SLVERR;
    end else if (w_addr_err) begin
      w_resp_now = DECERR;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_arready_nxt = 1'b0;
    w_rvalid_nxt  = r_rvalid;
    w_ar_hs       = 1'b0;
    w_r_hs        = 1'b0;
    case (r_state)
      IDLE: begin
        w_arready_nxt = 1'b1;
        w_rvalid_nxt  = 1'b0;
        if (ARVALID && r_arready) begin
          w_ar_hs       = 1'b1;
          w_arready_nxt = 1'b0;
          w_rvalid_nxt  = 1'b1;
          w_state_nxt   = BURST;
        end
      end
      BURST: begin
        w_r_hs = r_rvalid && RREADY;
        if (w_r_hs && r_rlast) begin
          w_rvalid_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_load = w_ar_hs || (w_r_hs && !r_rlast);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rid      <= '0;
      r_rdata    <= '0;
      r_rresp    <= OKAY;
      r_beat_cnt <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= FIXED;
      r_slverr   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      if (w_ar_hs) begin
        r_rid      <= ARID;
        r_len      <= ARLEN;
        r_size     <= ARSIZE;
        r_burst    <= burst_e'(ARBURST);
        r_slverr   <= w_burst_err;
        r_beat_cnt <= '0;
        r_rlast    <= (ARLEN == '0);
      end else if (w_r_hs && !r_rlast) begin
        r_beat_cnt <= r_beat_cnt + 4'd1;
        r_rlast    <= ((r_beat_cnt + 4'd1) == r_len);
      end else if (w_r_hs) begin
        r_rlast    <= 1'b0;
      end
      // r_addr always holds the address of the beat to be fetched next.
      if (w_load) begin
        r_addr  <= w_next_addr;
        r_rresp <= w_resp_now;
        r_rdata <= (w_resp_now == OKAY) ? mem[w_word_idx] : '0;
      end
    end
  end

  // Contents survive reset; same-edge preload leaves the old word on the read.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign ARREADY = r_arready;
  assign RVAILD  = r_rvalid;
  assign RLAST   = r_rlast;
  assign RID     = r_rid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

endmodule

`default_nettype wire
